// File: rtl/mul32_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle field multiplier among N_REQ requesters.
// Each requester gets a one-deep start latch; one multiplier operation is in flight at a time.
module mul32_share_arbiter #(
   parameter int N_REQ = 2,
   parameter int WIDTH = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [N_REQ-1:0]         i_req_start,
   input  logic [WIDTH*N_REQ-1:0]   i_req_x,
   input  logic [WIDTH*N_REQ-1:0]   i_req_y,
   output logic [WIDTH-1:0]         o_req_out,
   output logic [N_REQ-1:0]         o_req_done,
   output logic [N_REQ-1:0]         o_overrun,
   output logic                     o_busy,
   output logic                     o_start_mul,
   output logic [WIDTH-1:0]         o_x_mul,
   output logic [WIDTH-1:0]         o_y_mul,
   input  logic [WIDTH-1:0]         i_o_mul,
   input  logic                     i_done_mul
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);

   logic [1:0]         state_r;
   logic [N_REQ-1:0]   pending_r;
   logic [N_REQ-1:0]   overrun_r;
   logic [WIDTH-1:0]   x_lat_r [N_REQ];
   logic [WIDTH-1:0]   y_lat_r [N_REQ];
   logic [GW-1:0]      grant_r;
   logic [GW-1:0]      last_grant_r;
   logic [WIDTH-1:0]   out_r;
   logic [N_REQ-1:0]   done_r;
   logic               busy_r;
   logic               start_r;
   logic [WIDTH-1:0]   x_mul_r;
   logic [WIDTH-1:0]   y_mul_r;

   logic [GW-1:0]      pick_s;
   logic               pick_valid_s;
   int                 best_s;
   logic [N_REQ-1:0]   clear_s;

   // Round-robin pick: smallest distance after last_grant among pending requesters
   always_comb begin
      pick_s       = '0;
      pick_valid_s = 1'b0;
      best_s       = N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
         if (pending_r[j] && (((j - int'(last_grant_r) - 1 + 2 * N_REQ) % N_REQ) < best_s)) begin
            best_s       = (j - int'(last_grant_r) - 1 + 2 * N_REQ) % N_REQ;
            pick_s       = GW'(j);
            pick_valid_s = 1'b1;
         end else begin
            best_s = best_s;
         end
      end
   end

   // Pending bit being consumed by a grant this edge
   always_comb begin
      clear_s = '0;
      for (int k = 0; k < N_REQ; k++) begin
         clear_s[k] = (state_r == ST_IDLE) && pick_valid_s && (pick_s == GW'(k));
      end
   end

   // Per-requester start latch; a new start beats its own same-edge grant clear
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_r <= '0;
         overrun_r <= '0;
         for (int k = 0; k < N_REQ; k++) begin
            x_lat_r[k] <= '0;
            y_lat_r[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_REQ; k++) begin
            if (i_req_start[k]) begin
               if (pending_r[k] && !clear_s[k]) begin
                  overrun_r[k] <= 1'b1;
               end else begin
                  pending_r[k] <= 1'b1;
                  x_lat_r[k]   <= i_req_x[WIDTH*k +: WIDTH];
                  y_lat_r[k]   <= i_req_y[WIDTH*k +: WIDTH];
               end
            end else if (clear_s[k]) begin
               pending_r[k] <= 1'b0;
            end
         end
      end
   end

   // Issue/wait FSM driving the shared multiplier and the completion pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r      <= ST_IDLE;
         grant_r      <= '0;
         last_grant_r <= LAST_INIT;
         out_r        <= '0;
         done_r       <= '0;
         busy_r       <= 1'b0;
         start_r      <= 1'b0;
         x_mul_r      <= '0;
         y_mul_r      <= '0;
      end else begin
         done_r <= '0;
         case (state_r)
            ST_IDLE: begin
               if (pick_valid_s) begin
                  x_mul_r <= x_lat_r[pick_s];
                  y_mul_r <= y_lat_r[pick_s];
                  grant_r <= pick_s;
                  start_r <= 1'b1;
                  busy_r  <= 1'b1;
                  state_r <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               start_r <= 1'b0;
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_done_mul) begin
                  out_r        <= i_o_mul;
                  done_r       <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_r;
                  last_grant_r <= grant_r;
                  busy_r       <= 1'b0;
                  state_r      <= ST_IDLE;
               end
            end
            default: begin
               start_r <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_req_out   = out_r;
   assign o_req_done  = done_r;
   assign o_overrun   = overrun_r;
   assign o_busy      = busy_r;
   assign o_start_mul = start_r;
   assign o_x_mul     = x_mul_r;
   assign o_y_mul     = y_mul_r;

endmodule

// File: tb/tb_mul32_share_arbiter.sv
// Directed and scoreboard checks of mul32_share_arbiter with N_REQ=2 (fixed 3-cycle
// multiplier model) and N_REQ=4 (random 1..5-cycle multiplier model).
module tb_mul32_share_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]   start2 = '0;
   logic [63:0]  x2 = '0, y2 = '0;
   logic [31:0]  out2, xm2, ym2, om2;
   logic [1:0]   done2, ovr2;
   logic         busy2, smul2, dm2;

   logic [3:0]   start4 = '0;
   logic [127:0] x4 = '0, y4 = '0;
   logic [31:0]  out4, xm4, ym4, om4;
   logic [3:0]   done4, ovr4;
   logic         busy4, smul4, dm4;

   mul32_share_arbiter #(.N_REQ(2), .WIDTH(32)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_start(start2), .i_req_x(x2), .i_req_y(y2),
      .o_req_out(out2), .o_req_done(done2), .o_overrun(ovr2), .o_busy(busy2),
      .o_start_mul(smul2), .o_x_mul(xm2), .o_y_mul(ym2), .i_o_mul(om2), .i_done_mul(dm2)
   );

   mul32_share_arbiter #(.N_REQ(4), .WIDTH(32)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_start(start4), .i_req_x(x4), .i_req_y(y4),
      .o_req_out(out4), .o_req_done(done4), .o_overrun(ovr4), .o_busy(busy4),
      .o_start_mul(smul4), .o_x_mul(xm4), .o_y_mul(ym4), .i_o_mul(om4), .i_done_mul(dm4)
   );

   // Multiplier models: done pulses LAT cycles after the start is sampled; not reset on purpose
   logic [2:0]  cnt2 = 3'd0, cnt4 = 3'd0;
   logic [31:0] prod2 = 32'd0, prod4 = 32'd0;
   always @(posedge clk) begin
      if (smul2) begin
         cnt2  <= 3'd3;
         prod2 <= xm2 * ym2;
      end else if (cnt2 != 3'd0) begin
         cnt2 <= cnt2 - 3'd1;
      end
   end
   always @(posedge clk) begin
      if (smul4) begin
         cnt4  <= 3'($urandom_range(1, 5));
         prod4 <= xm4 * ym4;
      end else if (cnt4 != 3'd0) begin
         cnt4 <= cnt4 - 3'd1;
      end
   end
   assign om2 = prod2;
   assign dm2 = (cnt2 == 3'd1);
   assign om4 = prod4;
   assign dm4 = (cnt4 == 3'd1);

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start2 = '0;
      start4 = '0;
      rst_n  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Single request on dut2, checked cycle by cycle
   task automatic run_one(input int req, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] prod);
      int   n;
      bit   seen;
      bit   extra_start;
      logic [1:0] exp_done;
      exp_done = 2'b01 << req;
      start2 = '0;
      start2[req] = 1'b1;
      x2[32*req +: 32] = x;
      y2[32*req +: 32] = y;
      tick();
      start2 = '0;
      tick();
      chk("issue_start", 64'(smul2), 64'(1'b1));
      chk("issue_x", 64'(xm2), 64'(x));
      chk("issue_y", 64'(ym2), 64'(y));
      chk("issue_busy", 64'(busy2), 64'(1'b1));
      n = 0;
      seen = 1'b0;
      extra_start = 1'b0;
      while (!seen && n < 30) begin
         tick();
         n++;
         if (smul2) extra_start = 1'b1;
         if (done2 != 2'b00) seen = 1'b1;
      end
      chk("start_single_pulse", 64'(extra_start), 64'(1'b0));
      chk("done_latency", 64'(n), 64'(4));
      chk("done_onehot", 64'(done2), 64'(exp_done));
      chk("done_product", 64'(out2), 64'(prod));
      chk("done_busy_low", 64'(busy2), 64'(1'b0));
      tick();
      chk("done_cleared", 64'(done2), 64'(2'b00));
      chk("out_held", 64'(out2), 64'(prod));
   endtask

   int          cd [8];
   logic [31:0] co [8];
   int          cc [8];
   int          sc [8];
   int          nd, ns;

   // Record start pulses and completions on dut2 for a fixed number of cycles
   task automatic collect(input int budget);
      nd = 0;
      ns = 0;
      for (int c = 1; c <= budget; c++) begin
         tick();
         if (smul2) begin
            if (ns < 8) sc[ns] = c;
            ns++;
         end
         if (done2 != 2'b00) begin
            if (nd < 8) begin
               cd[nd] = int'(done2);
               co[nd] = out2;
               cc[nd] = c;
            end
            nd++;
         end
      end
   endtask

   task automatic run_pair(input logic [31:0] xa, input logic [31:0] ya, input logic [31:0] pa,
                           input logic [31:0] xb, input logic [31:0] yb, input logic [31:0] pb,
                           input int first);
      start2 = 2'b11;
      x2 = {xb, xa};
      y2 = {yb, ya};
      tick();
      start2 = '0;
      collect(25);
      chk("pair_done_count", 64'(nd), 64'(2));
      chk("pair_start_count", 64'(ns), 64'(2));
      chk("pair_first_req", 64'(cd[0]), 64'((first == 0) ? 2 'b01 : 2'b10));
      chk("pair_first_prod", 64'(co[0]), 64'((first == 0) ? pa : pb));
      chk("pair_second_req", 64'(cd[1]), 64'((first == 0) ? 2'b10 : 2'b01));
      chk("pair_second_prod", 64'(co[1]), 64'((first == 0) ? pb : pa));
      chk("pair_back_to_back", 64'(sc[1]), 64'(cc[0] + 1));
   endtask

   typedef struct {
      int          req;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] prod;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int   issued, completed, cyc;
      int   outst [4];
      int   gsince [4];
      logic [31:0] expp [4];
      logic [31:0] rx, ry;
      bit   quiet;

      vecs[0] = '{0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006};
      vecs[1] = '{1, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340};
      vecs[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[3] = '{1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
      vecs[4] = '{1, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000};
      vecs[5] = '{0, 32'h0000_00FF, 32'h0000_0101, 32'h0000_FFFF};

      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_out", 64'(out2), 64'(0));
      chk("rst_done", 64'(done2), 64'(0));
      chk("rst_overrun", 64'(ovr2), 64'(0));
      chk("rst_busy", 64'(busy2), 64'(0));
      chk("rst_start", 64'(smul2), 64'(0));
      chk("rst_xy", 64'({xm2, ym2}), 64'(0));
      do_reset();

      for (int i = 0; i < 6; i++) begin
         run_one(vecs[i].req, vecs[i].x, vecs[i].y, vecs[i].prod);
      end

      // Simultaneous starts, then rotation after a lone req0 op
      do_reset();
      run_pair(32'h11, 32'h3, 32'h33, 32'h100, 32'h100, 32'h1_0000, 0);
      run_one(0, 32'h2, 32'h2, 32'h4);
      run_pair(32'h6, 32'h7, 32'h2A, 32'h8000_0000, 32'h2, 32'h0, 1);

      // Overrun: req1 restarts while still pending behind req0's op
      do_reset();
      start2 = 2'b01; x2[31:0] = 32'd5; y2[31:0] = 32'd6;
      tick();
      start2 = 2'b00;
      tick();
      start2 = 2'b10; x2[63:32] = 32'd3; y2[63:32] = 32'd4;
      tick();
      start2 = 2'b10; x2[63:32] = 32'd9; y2[63:32] = 32'd9;
      tick();
      start2 = 2'b00;
      chk("ovr_flag", 64'(ovr2), 64'(2'b10));
      collect(20);
      chk("ovr_done_count", 64'(nd), 64'(2));
      chk("ovr_req0", 64'({cd[0], co[0]}), {32'd1, 32'd30});
      chk("ovr_req1_first_ops", 64'({cd[1], co[1]}), {32'd2, 32'd12});
      chk("ovr_sticky", 64'(ovr2), 64'(2'b10));

      // Same-edge requeue: new start on the edge its pending bit is granted
      do_reset();
      start2 = 2'b01; x2[31:0] = 32'd2; y2[31:0] = 32'd5;
      tick();
      x2[31:0] = 32'd7; y2[31:0] = 32'd8;
      tick();
      start2 = 2'b00;
      chk("requeue_no_ovr", 64'(ovr2), 64'(2'b00));
      collect(20);
      chk("requeue_done_count", 64'(nd), 64'(2));
      chk("requeue_first", 64'({cd[0], co[0]}), {32'd1, 32'd10});
      chk("requeue_second", 64'({cd[1], co[1]}), {32'd1, 32'd56});
      chk("requeue_no_ovr_end", 64'(ovr2), 64'(2'b00));

      // Reset during WAIT, stale multiplier done afterwards
      do_reset();
      start2 = 2'b01; x2[31:0] = 32'd4; y2[31:0] = 32'd4;
      tick();
      start2 = 2'b00;
      tick();
      tick();
      chk("midop_busy", 64'(busy2), 64'(1'b1));
      tick();
      rst_n = 1'b0;
      #1;
      chk("midop_rst_outs", 64'({busy2, smul2, done2, ovr2}), 64'(0));
      chk("midop_rst_xy", 64'({xm2, ym2}), 64'(0));
      tick();
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (done2 != 2'b00 || busy2 || smul2) quiet = 1'b0;
      end
      chk("midop_stale_done_ignored", 64'(quiet), 64'(1'b1));
      run_one(1, 32'd3, 32'd5, 32'd15);

      // Stress on the 4-requester instance against a scoreboard
      do_reset();
      issued = 0;
      completed = 0;
      cyc = 0;
      for (int k = 0; k < 4; k++) begin
         outst[k] = 0;
         gsince[k] = 0;
         expp[k] = '0;
      end
      while ((issued < 1000 || completed < issued) && cyc < 20000) begin
         if (smul4) begin
            for (int k = 0; k < 4; k++) if (outst[k] != 0) gsince[k]++;
         end
         if (done4 != 4'b0000) begin
            chk("stress_onehot", 64'($countones(done4)), 64'(1));
            for (int k = 0; k < 4; k++) begin
               if (done4[k]) begin
                  chk("stress_outstanding", 64'(outst[k]), 64'(1));
                  chk("stress_product", 64'(out4), 64'(expp[k]));
                  chk("stress_fairness", 64'(gsince[k] <= 4), 64'(1'b1));
                  outst[k] = 0;
                  completed++;
               end
            end
         end
         start4 = '0;
         for (int k = 0; k < 4; k++) begin
            if (issued < 1000 && outst[k] == 0 && $urandom_range(0, 1) == 1) begin
               rx = $urandom;
               ry = $urandom;
               start4[k] = 1'b1;
               x4[32*k +: 32] = rx;
               y4[32*k +: 32] = ry;
               expp[k] = rx * ry;
               outst[k] = 1;
               gsince[k] = 0;
               issued++;
            end
         end
         tick();
         cyc++;
      end
      start4 = '0;
      chk("stress_timeout", 64'(cyc < 20000), 64'(1'b1));
      chk("stress_completed", 64'(completed), 64'(1000));
      chk("stress_no_overrun", 64'(ovr4), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
